custom_ip_regif: RTL and testbench

APB-slave register front end for custom_ip blocks: it owns the software-visible register bank, drives the reg2ip data/strobe interface into the IP, and absorbs ip2reg update strobes from the IP. It sits between the SoC peripheral APB interconnect and one custom IP instance. It adds sticky hardware-update status bits, a mask, and a level interrupt.

---
 rtl/custom_ip_regif.sv | 162 ++++++++++++++++
 tb/tb_custom_ip_regif.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_regif.sv
// APB register front end for a custom IP: register bank, reg2ip/ip2reg ports, sticky STATUS, MASK and level irq.
// Latency: fixed 3-cycle APB transfer (setup, one wait state, pready on the third cycle); ip2reg loads land next edge.
// Backpressure: none toward the IP; the APB side always inserts exactly one wait state and never stalls further.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   paddr_i/psel_i/penable_i/pwrite_i/pwdata_i   APB request
//   pstrb_i                       byte strobes (only with CUSTOM_IP_REGIF_PSTRB_EN defined)
//   prdata_o/pready_o/pslverr_o   registered APB response
//   reg2ip_data_o/reg2ip_en_o     register contents and one-cycle SW-write pulse per register
//   ip2reg_data_i/ip2reg_en_i     hardware load of register contents; sets the matching STATUS bit
//   irq_o                         registered |(STATUS & MASK)
// Optional feature macro: CUSTOM_IP_REGIF_PSTRB_EN (byte-lane writes via pstrb_i).
module custom_ip_regif #(
  parameter int NUM_REGS   = 3,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDR_WIDTH-1:0]    paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [31:0]              pwdata_i,
`ifdef CUSTOM_IP_REGIF_PSTRB_EN
  input  logic [3:0]               pstrb_i,
`endif
  output logic [31:0]              prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [NUM_REGS*32-1:0]   reg2ip_data_o,
  output logic [NUM_REGS-1:0]      reg2ip_en_o,
  input  logic [NUM_REGS*32-1:0]   ip2reg_data_i,
  input  logic [NUM_REGS-1:0]      ip2reg_en_i,
  output logic                     irq_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS);
  localparam logic [IW-1:0] MASK_IDX   = IW'(NUM_REGS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [31:0]           r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_status;
  logic [NUM_REGS-1:0]   r_mask;
  logic                  r_irq;
  logic [31:0]           r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [NUM_REGS-1:0]   r_reg2ip_en;

  logic [IW-1:0]         w_idx;
  logic                  w_dec_err;
  logic                  w_access;
  logic                  w_wr_ok;
  logic [3:0]            w_strb;
  logic [31:0]           w_bmask;
  logic [31:0]           w_wdm;
  logic [NUM_REGS-1:0]   w_reg_sel;
  logic                  w_status_we;
  logic                  w_mask_we;
  logic [NUM_REGS-1:0]   w_w1c;
  logic [31:0]           w_rdata;

`ifdef CUSTOM_IP_REGIF_PSTRB_EN
  assign w_strb = pstrb_i;
`else
  assign w_strb = 4'hF;
`endif

  assign w_idx       = paddr_i[ADDR_WIDTH-1:2];
  assign w_dec_err   = (paddr_i[1:0] != 2'b00) || (w_idx > MASK_IDX);
  // Commit happens only on the access cycle; anything else in WAIT is an abort.
  assign w_access    = (r_state == S_WAIT) && psel_i && penable_i;
  assign w_wr_ok     = w_access && pwrite_i && !w_dec_err;
  assign w_bmask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign w_wdm       = pwdata_i & w_bmask;
  assign w_status_we = w_wr_ok && (w_idx == STATUS_IDX);
  assign w_mask_we   = w_wr_ok && (w_idx == MASK_IDX);
  assign w_w1c       = w_status_we ? w_wdm[NUM_REGS-1:0] : '0;

  always_comb begin
    w_reg_sel = '0;
    w_rdata   = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_reg_sel[k] = w_wr_ok && (w_idx == IW'(k));
      if (w_idx == IW'(k)) w_rdata = r_regs[k];
    end
    if (w_idx == STATUS_IDX) w_rdata[NUM_REGS-1:0] = r_status;
    if (w_idx == MASK_IDX)   w_rdata[NUM_REGS-1:0] = r_mask;
  end

  // Register bank, STATUS, MASK and irq.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_reg_sel[k]) begin
          // SW lanes win; unstrobed lanes still take a coincident hardware load.
          r_regs[k] <= ((ip2reg_en_i[k] ? ip2reg_data_i[32*k +: 32] : r_regs[k]) & ~w_bmask) | w_wdm;
        end else if (ip2reg_en_i[k]) begin
          r_regs[k] <= ip2reg_data_i[32*k +: 32];
        end
      end
      // Clear first, then set, so a coincident hardware set survives W1C.
      r_status <= (r_status & ~w_w1c) | ip2reg_en_i;
      if (w_mask_we) r_mask <= (r_mask & ~w_bmask[NUM_REGS-1:0]) | w_wdm[NUM_REGS-1:0];
      r_irq <= |(r_status & r_mask);
    end
  end

  // APB transfer FSM; all response outputs are one-cycle registered pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_reg2ip_en <= '0;
    end else begin
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_reg2ip_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (psel_i && !penable_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (psel_i && penable_i) begin
            r_state     <= S_RESP;
            r_pready    <= 1'b1;
            r_pslverr   <= w_dec_err;
            r_prdata    <= (!pwrite_i && !w_dec_err) ? w_rdata : '0;
            r_reg2ip_en <= (|w_strb) ? w_reg_sel : '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg2ip_data_o[32*g +: 32] = r_regs[g];
  end

  assign prdata_o    = r_prdata;
  assign pready_o    = r_pready;
  assign pslverr_o   = r_pslverr;
  assign reg2ip_en_o = r_reg2ip_en;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_custom_ip_regif.sv
// Bench for custom_ip_regif: randomized APB and ip2reg traffic against a register-map model.
// Latency: expects pready on the third cycle of each transfer and irq two cycles after a masked hardware update.
// Backpressure: none; responses are popped from a scoreboard queue whenever pready is seen.
module tb_custom_ip_regif;

  localparam int NR = 3;
  localparam int AW = 12;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     paddr_i;
  logic              psel_i, penable_i, pwrite_i;
  logic [31:0]       pwdata_i;
`ifdef CUSTOM_IP_REGIF_PSTRB_EN
  logic [3:0]        pstrb_i = 4'hF;
`endif
  logic [31:0]       prdata_o;
  logic              pready_o, pslverr_o;
  logic [NR*32-1:0]  reg2ip_data_o;
  logic [NR-1:0]     reg2ip_en_o;
  logic [NR*32-1:0]  ip2reg_data_i;
  logic [NR-1:0]     ip2reg_en_i;
  logic              irq_o;

  custom_ip_regif #(.NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .psel_i(psel_i),
    .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
`ifdef CUSTOM_IP_REGIF_PSTRB_EN
    .pstrb_i(pstrb_i),
`endif
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
    .ip2reg_data_i(ip2reg_data_i), .ip2reg_en_i(ip2reg_en_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   rdata;
    logic          slverr;
    logic [NR-1:0] en;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model of the software-visible map.
  logic [31:0]   m_regs [NR];
  logic [NR-1:0] m_status;
  logic [NR-1:0] m_mask;

  function automatic logic m_irq();
    return |(m_status & m_mask);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_status = '0;
    m_mask   = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every pready and checks the pulse is one cycle wide.
  logic prev_rdy = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni !== 1'b1) begin
      prev_rdy = 1'b0;
    end else begin
      if (prev_rdy) begin
        chk("pready_width", {31'b0, pready_o}, 32'd0);
        chk("reg2ip_en_width", 32'(reg2ip_en_o), 32'd0);
      end
      prev_rdy = (pready_o === 1'b1);
      if (pready_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pready: got pready=1 expected no transfer at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("prdata", prdata_o, e.rdata);
          chk("pslverr", {31'b0, pslverr_o}, {31'b0, e.slverr});
          chk("reg2ip_en", 32'(reg2ip_en_o), 32'(e.en));
        end
      end
    end
  end

  // Full APB transfer; optional hardware update driven during the access cycle.
  // Entered and left at #1 after a rising edge.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                          input logic [NR-1:0] hen, input logic [NR*32-1:0] hdat);
    exp_t e;
    int   idx;
    logic err;
    int   cnt;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = w; pwdata_i = d;
    @(posedge clk_i); #1;
    penable_i = 1'b1; ip2reg_en_i = hen; ip2reg_data_i = hdat;
    idx = int'(a >> 2);
    err = (a[1:0] != 2'b00) || (idx > NR + 1);
    e.rdata = '0; e.slverr = err; e.en = '0;
    if (!err && !w) begin
      if (idx < NR)       e.rdata = m_regs[idx];
      else if (idx == NR) e.rdata = 32'(m_status);
      else                e.rdata = 32'(m_mask);
    end
    for (int k = 0; k < NR; k++) if (hen[k]) m_regs[k] = hdat[32*k +: 32];
    if (!err && w) begin
      if (idx < NR) begin
        m_regs[idx] = d;
        e.en = NR'(1) << idx;
      end else if (idx == NR) begin
        m_status = m_status & ~d[NR-1:0];
      end else begin
        m_mask = d[NR-1:0];
      end
    end
    m_status = m_status | hen;
    exp_q.push_back(e);
    @(negedge clk_i);
    chk("t1_pready_low", {31'b0, pready_o}, 32'd0);
    @(posedge clk_i); #1;
    ip2reg_en_i = '0;
    cnt = 0;
    while (pready_o !== 1'b1 && cnt < 5) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    chk("t2_latency", 32'(cnt), 32'd0);
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    apb_xfer(a, 1'b0, 32'd0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    apb_xfer(a, 1'b1, d, '0, '0);
  endtask

  // Hardware load outside any transfer; checks data lands after one edge and irq one edge later.
  task automatic hw_update(input logic [NR-1:0] hen, input logic [NR*32-1:0] hdat);
    logic irq_old;
    irq_old = m_irq();
    ip2reg_en_i = hen; ip2reg_data_i = hdat;
    @(posedge clk_i); #1;
    ip2reg_en_i = '0;
    for (int k = 0; k < NR; k++) if (hen[k]) m_regs[k] = hdat[32*k +: 32];
    m_status = m_status | hen;
    @(negedge clk_i);
    for (int k = 0; k < NR; k++) chk("hw_reg2ip_data", reg2ip_data_o[32*k +: 32], m_regs[k]);
    chk("irq_lag", {31'b0, irq_o}, {31'b0, irq_old});
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("irq_after_hw", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk_i); #1;
  endtask

  task automatic check_outputs();
    @(negedge clk_i);
    for (int k = 0; k < NR; k++) chk("reg2ip_data", reg2ip_data_o[32*k +: 32], m_regs[k]);
    chk("irq", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk_i); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_prdata"}, prdata_o, 32'd0);
    chk({tag, "_pready"}, {31'b0, pready_o}, 32'd0);
    chk({tag, "_pslverr"}, {31'b0, pslverr_o}, 32'd0);
    chk({tag, "_reg2ip_en"}, 32'(reg2ip_en_o), 32'd0);
    chk({tag, "_irq"}, {31'b0, irq_o}, 32'd0);
    for (int k = 0; k < NR; k++) chk({tag, "_reg2ip_data"}, reg2ip_data_o[32*k +: 32], 32'd0);
  endtask

  logic [NR*32-1:0] hd;
  logic [AW-1:0]    ra;

  initial begin
    rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; ip2reg_en_i = '0; ip2reg_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Every mapped offset reads zero after reset.
    for (int i = 0; i <= NR + 1; i++) rd(AW'(4 * i));
    check_outputs();

    // Plain SW write and readback.
    wr(12'h004, 32'hDEADBEEF);
    rd(12'h004);
    check_outputs();

    // Hardware update with mask set, then W1C.
    wr(12'(4 * (NR + 1)), 32'h4);
    hd = '0; hd[64 +: 32] = 32'h1234;
    hw_update(3'b100, hd);
    rd(12'h008);
    rd(12'(4 * NR));
    check_outputs();
    wr(12'(4 * NR), 32'h4);
    rd(12'(4 * NR));
    check_outputs();

    // SW write colliding with hardware update; W1C colliding with hardware set.
    hd = '0; hd[0 +: 32] = 32'h5555;
    apb_xfer(12'h000, 1'b1, 32'hAAAA, 3'b001, hd);
    rd(12'h000);
    rd(12'(4 * NR));
    apb_xfer(12'(4 * NR), 1'b1, 32'h1, 3'b001, hd);
    rd(12'(4 * NR));
    check_outputs();

    // Decode errors: out of range, misaligned, one past MASK.
    rd(12'h100);
    wr(12'h100, 32'hFFFF_FFFF);
    rd(12'h002);
    wr(12'h002, 32'hFFFF_FFFF);
    wr(12'(4 * (NR + 2)), 32'hFFFF_FFFF);
    check_outputs();

    // Abort: psel dropped in the wait cycle.
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 12'h000; pwrite_i = 1'b1; pwdata_i = 32'h0BAD_0BAD;
    @(posedge clk_i); #1;
    psel_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("abort_pready", {31'b0, pready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    pwrite_i = 1'b0;
    check_outputs();
    rd(12'h000);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) ra = AW'(4 * (NR + 2) + 4 * $urandom_range(0, 200));
        else                           ra = AW'(4 * $urandom_range(0, NR + 1) + $urandom_range(1, 3));
      end else begin
        ra = AW'(4 * $urandom_range(0, NR + 1));
      end
      for (int k = 0; k < NR; k++) hd[32*k +: 32] = $urandom;
      apb_xfer(ra, 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0, hd);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NR; k++) hd[32*k +: 32] = $urandom;
        hw_update(NR'($urandom_range(1, (1 << NR) - 1)), hd);
      end
      if ($urandom_range(0, 1) == 1) check_outputs();
    end

    // Reset asserted in the wait cycle of a write drops it.
    wr(12'(4 * (NR + 1)), 32'hFFFF_FFFF);
    hd = '1;
    hw_update('1, hd);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 12'h000; pwrite_i = 1'b1; pwdata_i = 32'h1111;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    #2 rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    check_all_zero("midreset");
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check_outputs();
    rd(12'h000);
    rd(12'(4 * NR));
    rd(12'(4 * (NR + 1)));

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
